// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_loader
// Purpose  : Accepts the PAL configuration bitstream as bytes over a
//            valid/ready handshake and serialises it LSB-first onto the PAL's
//            one-bit CFG input. It gives one CFG_SHIFT strobe per bit, then a
//            one-cycle CFG_APPLY (PAL EN), then a one-cycle DONE.
// Ports    : CLK, RES (async, active-high)
//            START, ABORT              - frame control
//            DATA_IN[7:0], DATA_VALID  - byte source
//            DATA_READY                - byte accepted this cycle
//            CFG_DATA, CFG_SHIFT       - serial bit + bit-valid strobe
//            CFG_APPLY                 - commit strobe
//            BUSY, DONE                - status
// Revision : 1.0 - initial release
// ============================================================================
module pal_cfg_loader #(
  parameter int CFG_BITS = 280
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       CFG_DATA,
  output logic       CFG_SHIFT,
  output logic       CFG_APPLY,
  output logic       BUSY,
  output logic       DONE
);

  localparam int NUM_BYTES = (CFG_BITS + 7) / 8;
  localparam int c_BIT_W   = $clog2(CFG_BITS + 1);
  localparam int c_BYTE_W  = $clog2(NUM_BYTES + 1);

  localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(CFG_BITS);
  localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SHIFT  = 3'd2,
    S_APPLY  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [c_BYTE_W-1:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic [6:0]            r_sreg, w_sreg_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_cfg_data, w_cfg_data_nxt;
  logic                  r_cfg_shift, w_cfg_shift_nxt;
  logic                  r_apply, w_apply_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  // Low three bits of the bit counter give the position within the current
  // byte; a zero there (with the counter non-zero) means a byte boundary.
  logic [2:0] w_bit_lo;
  logic       w_last_bit;

  assign w_bit_lo   = 3'(r_bit_cnt);
  assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

  // All outputs are registered: the combinational block computes the value
  // each output takes in the *next* state, so output and state move together.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_sreg_nxt      = r_sreg;
    w_cfg_data_nxt  = r_cfg_data;
    w_ready_nxt     = 1'b0;
    w_cfg_shift_nxt = 1'b0;
    w_apply_nxt     = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;

    if (ABORT) begin
      // Abort outranks everything, including START in IDLE.
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            w_state_nxt    = S_WAIT;
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = '0;
            w_ready_nxt    = 1'b1;
            w_busy_nxt     = 1'b1;
          end
        end

        S_WAIT: begin
          w_busy_nxt = 1'b1;
          // The byte-count guard keeps the counter from wrapping even if the
          // frame bookkeeping were ever disturbed.
          if (DATA_VALID && (r_byte_cnt != c_LAST_BYTE)) begin
            // First bit leaves on the handshake edge; the rest queue up.
            w_state_nxt     = S_SHIFT;
            w_cfg_data_nxt  = DATA_IN[0];
            w_sreg_nxt      = DATA_IN[7:1];
            w_cfg_shift_nxt = 1'b1;
            w_bit_cnt_nxt   = r_bit_cnt + c_BIT_W'(1);
            w_byte_cnt_nxt  = r_byte_cnt + c_BYTE_W'(1);
          end else begin
            w_ready_nxt = 1'b1;
          end
        end

        S_SHIFT: begin
          w_busy_nxt = 1'b1;
          if (w_last_bit) begin
            // Partial last byte: remaining upper bits are simply dropped.
            w_state_nxt = S_APPLY;
            w_apply_nxt = 1'b1;
          end else if (w_bit_lo == 3'd0) begin
            w_state_nxt = S_WAIT;
            w_ready_nxt = 1'b1;
          end else begin
            w_cfg_data_nxt  = r_sreg[0];
            w_sreg_nxt      = {1'b0, r_sreg[6:1]};
            w_cfg_shift_nxt = 1'b1;
            w_bit_cnt_nxt   = r_bit_cnt + c_BIT_W'(1);
          end
        end

        S_APPLY: begin
          w_state_nxt = S_FINISH;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
        end

        S_FINISH: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_sreg      <= '0;
      r_ready     <= 1'b0;
      r_cfg_data  <= 1'b0;
      r_cfg_shift <= 1'b0;
      r_apply     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_sreg      <= w_sreg_nxt;
      r_ready     <= w_ready_nxt;
      r_cfg_data  <= w_cfg_data_nxt;
      r_cfg_shift <= w_cfg_shift_nxt;
      r_apply     <= w_apply_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign DATA_READY = r_ready;
  assign CFG_DATA   = r_cfg_data;
  assign CFG_SHIFT  = r_cfg_shift;
  assign CFG_APPLY  = r_apply;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule
`default_nettype wire
